// File: rtl/conv_requant_if.sv
// Valid/ready stream bundle used on both sides of conv_requant.
// WIDTH is the packed data width carried by one transfer.
interface conv_requant_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/conv_requant.sv
// Requantizer after the conv bias adder: scale, rounding shift, zero point, int8 saturation.
// Optional RELU_EN macro raises the lower saturation bound to the zero point.
module conv_requant #(
  parameter int PICTURE_NUM           = 1,
  parameter int CHANNEL_OUT_NUM       = 8,
  parameter int WIDTH_DATA_ADD        = 32,
  parameter int WIDTH_DATA_OUT        = 8,
  parameter int WIDTH_FEATURE_SIZE    = 12,
  parameter int WIDTH_CHANNEL_NUM_REG = 10
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      Start,
  input  logic [WIDTH_CHANNEL_NUM_REG-1:0]          Channel_Out_Num_REG,
  input  logic [WIDTH_FEATURE_SIZE-1:0]             Pixel_Num_REG,
  input  logic [WIDTH_DATA_ADD*CHANNEL_OUT_NUM-1:0] scale_in,
  input  logic [5:0]                                shift_in,
  input  logic [WIDTH_DATA_OUT-1:0]                 zp_in,
  conv_requant_if.slave                             s,
  conv_requant_if.master                            m,
  output logic                                      Next_Group,
  output logic                                      Layer_Done
);

  localparam int LANES = PICTURE_NUM * CHANNEL_OUT_NUM;
  localparam int WA    = WIDTH_DATA_ADD;
  localparam int WO    = WIDTH_DATA_OUT;
  localparam int WF    = WIDTH_FEATURE_SIZE;
  localparam int WC    = WIDTH_CHANNEL_NUM_REG;
  localparam int PW    = 2 * WA;
  localparam int RW    = PW + 1;
  localparam int VW    = PW + 2;

  localparam logic signed [VW-1:0] OMAX = VW'(2 ** (WO - 1) - 1);
  localparam logic signed [VW-1:0] OMIN = VW'(-(2 ** (WO - 1)));

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_d;

  logic [WF-1:0] pix, pix_num;
  logic [WC-1:0] grp, grp_num;

  logic en, accept, pix_last, grp_last, last_out, bad_cfg;
  logic v1, v2;
  logic [5:0] sh1;
  logic [WO-1:0] zp1, zp2;

  logic signed [PW-1:0] p_d [LANES];
  logic signed [PW-1:0] p_q [LANES];
  logic signed [RW-1:0] r_d [LANES];
  logic signed [RW-1:0] r_q [LANES];
  logic [WO-1:0] o_d [LANES];

  function automatic logic signed [RW-1:0] rshift(
    input logic signed [PW-1:0] p,
    input logic [5:0]           sh
  );
    logic signed [RW-1:0] ext, half;
    ext  = RW'(p);
    half = RW'(1) << (sh - 6'd1);
    if (sh == 6'd0) rshift = ext;
    else            rshift = (ext + half) >>> sh;
  endfunction

  function automatic logic [WO-1:0] sat(
    input logic signed [RW-1:0] r,
    input logic signed [WO-1:0] z
  );
    logic signed [VW-1:0] v, lo;
    v = VW'(r) + VW'(z);
`ifdef RELU_EN
    lo = VW'(z);
`else
    lo = OMIN;
`endif
    if (v > OMAX)    sat = OMAX[WO-1:0];
    else if (v < lo) sat = lo[WO-1:0];
    else             sat = v[WO-1:0];
  endfunction

  // One enable for the whole pipe keeps lanes and their shift/zp aligned.
  assign en       = !m.valid | m.ready;
  assign s.ready  = en & (state == RUN);
  assign accept   = s.valid & s.ready;
  assign pix_last = (pix == pix_num - WF'(1));
  assign grp_last = (grp == grp_num - WC'(1));
  assign last_out = m.valid & m.ready & !v1 & !v2;
  assign bad_cfg  = (Pixel_Num_REG == '0) ||
                    (Channel_Out_Num_REG < WC'(CHANNEL_OUT_NUM));

  always_comb begin
    state_d    = state;
    Next_Group = 1'b0;
    Layer_Done = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_d = bad_cfg ? DONE : RUN;
      end
      RUN: begin
        Next_Group = accept & pix_last;
        if (accept && pix_last && grp_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_out) begin
          state_d    = IDLE;
          Layer_Done = 1'b1;
        end
      end
      DONE: begin
        state_d    = IDLE;
        Layer_Done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix     <= '0;
      grp     <= '0;
      pix_num <= '0;
      grp_num <= '0;
    end else if (state == IDLE && Start) begin
      pix     <= '0;
      grp     <= '0;
      pix_num <= Pixel_Num_REG;
      grp_num <= Channel_Out_Num_REG / WC'(CHANNEL_OUT_NUM);
    end else if (accept) begin
      if (pix_last) begin
        pix <= '0;
        grp <= grp_last ? '0 : grp + WC'(1);
      end else begin
        pix <= pix + WF'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      p_d[k] = PW'($signed(s.data[k*WA +: WA])) *
               PW'($signed(scale_in[(k / PICTURE_NUM)*WA +: WA]));
      r_d[k] = rshift(p_q[k], sh1);
      o_d[k] = sat(r_q[k], zp2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      m.valid <= 1'b0;
      sh1     <= '0;
      zp1     <= '0;
      zp2     <= '0;
      m.data  <= '0;
      for (int k = 0; k < LANES; k++) begin
        p_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else if (en) begin
      v1      <= accept;
      v2      <= v1;
      m.valid <= v2;
      if (accept) begin
        sh1 <= shift_in;
        zp1 <= zp_in;
      end
      if (v1) zp2 <= zp1;
      for (int k = 0; k < LANES; k++) begin
        if (accept) p_q[k] <= p_d[k];
        if (v1)     r_q[k] <= r_d[k];
        if (v2)     m.data[k*WO +: WO] <= o_d[k];
      end
    end
  end

endmodule

// File: tb/tb_conv_requant.sv
// Self-checking bench for conv_requant: directed vector table plus random
// streams, stall and mid-layer reset sequences against an arithmetic model.
module tb_conv_requant;

  localparam int LANES = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [9:0]   ch_reg;
  logic [11:0]  pix_reg;
  logic [255:0] scale;
  logic [5:0]   shift;
  logic [7:0]   zp;
  logic         next_group;
  logic         layer_done;

  always #5 clk = ~clk;

  conv_requant_if #(.WIDTH(256)) s_bus ();
  conv_requant_if #(.WIDTH(64))  m_bus ();

  conv_requant dut (
    .clk                 (clk),
    .rst                 (rst),
    .Start               (start),
    .Channel_Out_Num_REG (ch_reg),
    .Pixel_Num_REG       (pix_reg),
    .scale_in            (scale),
    .shift_in            (shift),
    .zp_in               (zp),
    .s                   (s_bus),
    .m                   (m_bus),
    .Next_Group          (next_group),
    .Layer_Done          (layer_done)
  );

  typedef struct {
    logic signed [31:0] lane;
    logic signed [31:0] sc;
    int                 sh;
    logic signed [7:0]  z;
    logic signed [7:0]  ex;
    logic signed [7:0]  ex_relu;
  } vec_t;

  vec_t vecs [12];

  int checks   = 0;
  int failures = 0;

  logic [255:0] items [16];
  logic [255:0] sc_g  [4];
  int           sh_g  [4];
  logic [7:0]   zp_g  [4];
  logic [63:0]  exp_q [$];
  int           n_in, n_out;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference: exact product, floor((p + 2^(sh-1)) / 2^sh), add zp, clamp.
  function automatic logic [7:0] ref_q(input logic signed [31:0] lane,
                                       input logic signed [31:0] sc,
                                       input int sh,
                                       input logic signed [7:0] z);
    logic signed [127:0] p, b, num, den, q, v, lo;
    p = lane;
    b = sc;
    p = p * b;
    if (sh == 0) begin
      q = p;
    end else begin
      den = 1;
      den = den <<< sh;
      num = p + den / 2;
      q   = num / den;
      if ((num % den) != 0 && num < 0) q = q - 1;
    end
    v = q + z;
`ifdef RELU_EN
    lo = z;
`else
    lo = -128;
`endif
    if (v > 127)     v = 127;
    else if (v < lo) v = lo;
    return v[7:0];
  endfunction

  function automatic logic [63:0] ref_vec(input logic [255:0] d,
                                          input logic [255:0] sc,
                                          input int sh, input logic [7:0] z);
    logic [63:0] r;
    for (int k = 0; k < LANES; k++)
      r[k*8 +: 8] = ref_q(d[k*32 +: 32], sc[k*32 +: 32], sh, z);
    return r;
  endfunction

  task automatic start_layer(input logic [9:0] ch, input logic [11:0] px);
    @(negedge clk);
    start   = 1'b1;
    ch_reg  = ch;
    pix_reg = px;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rand_setup(input int n);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < LANES; k++) items[i][k*32 +: 32] = $urandom;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < LANES; k++)
        sc_g[g][k*32 +: 32] = $urandom_range(0, 65535) - 32'd32768;
      sh_g[g] = $urandom_range(30, 44);
      zp_g[g] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    logic signed [7:0] e;
`ifdef RELU_EN
    e = v.ex_relu;
`else
    e = v.ex;
`endif
    start_layer(10'd8, 12'd1);
    s_bus.valid = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      s_bus.data[k*32 +: 32] = v.lane;
      scale[k*32 +: 32]      = v.sc;
    end
    shift       = 6'(v.sh);
    zp          = v.z;
    m_bus.ready = 1'b1;
    #1;
    chk({name, "_s_ready"}, 128'(s_bus.ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    s_bus.valid = 1'b0;
    lat = 1;
    while (!m_bus.valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 128'(lat), 128'(3));
    chk({name, "_data"}, 128'(m_bus.data), 128'({8{e}}));
    chk({name, "_layer_done"}, 128'(layer_done), 128'(1));
    @(negedge clk);
    chk({name, "_one_cycle"}, 128'({m_bus.valid, layer_done}), 128'(0));
  endtask

  task automatic stream(input string tag, input int total, input int gsize,
                        input int pv, input int pr);
    int          cyc = 0;
    int          g, idx;
    bit          pend = 1'b0;
    bit          hold = 1'b0;
    logic [63:0] held, e;
    while (n_out < total && cyc < 600) begin
      if (!pend && n_in < total && $urandom_range(0, 99) < pv) pend = 1'b1;
      idx         = (n_in < total) ? n_in : total - 1;
      g           = idx / gsize;
      s_bus.valid = pend;
      s_bus.data  = items[idx];
      scale       = sc_g[g];
      shift       = 6'(sh_g[g]);
      zp          = zp_g[g];
      m_bus.ready = ($urandom_range(0, 99) < pr);
      #1;
      if (hold)
        chk({tag, "_hold"}, 128'({m_bus.valid, m_bus.data}), 128'({1'b1, held}));
      if (s_bus.valid && s_bus.ready) begin
        exp_q.push_back(ref_vec(items[idx], sc_g[g], sh_g[g], zp_g[g]));
        chk({tag, "_next_group"}, 128'(next_group),
            128'((n_in % gsize) == gsize - 1));
        n_in++;
        pend = 1'b0;
      end else begin
        chk({tag, "_next_group_idle"}, 128'(next_group), 128'(0));
      end
      if (m_bus.valid && m_bus.ready) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_unexpected_out"}, 128'(m_bus.data), 128'(0));
          chk({tag, "_unexpected_cnt"}, 128'(n_out + 1), 128'(n_in));
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_data"}, 128'(m_bus.data), 128'(e));
        end
        chk({tag, "_layer_done"}, 128'(layer_done), 128'(n_out == total - 1));
        n_out++;
      end else begin
        chk({tag, "_layer_done_idle"}, 128'(layer_done), 128'(0));
      end
      hold = m_bus.valid && !m_bus.ready;
      held = m_bus.data;
      @(negedge clk);
      cyc++;
    end
    s_bus.valid = 1'b0;
    m_bus.ready = 1'b1;
    chk({tag, "_out_count"}, 128'(n_out), 128'(total));
    @(negedge clk);
    chk({tag, "_idle_after"}, 128'({m_bus.valid, s_bus.ready, layer_done}), 128'(0));
  endtask

  initial begin
    int          cyc, seen;
    logic [63:0] held;

    rst         = 1'b1;
    start       = 1'b0;
    ch_reg      = '0;
    pix_reg     = '0;
    scale       = '0;
    shift       = '0;
    zp          = '0;
    s_bus.valid = 1'b0;
    s_bus.data  = '0;
    m_bus.ready = 1'b0;

    vecs[0]  = '{32'sd1000, 32'sh4000_0000, 31, 8'sd0, 8'sd127, 8'sd127};
    vecs[1]  = '{32'sd100, 32'sh4000_0000, 31, 8'sd0, 8'sd50, 8'sd50};
    vecs[2]  = '{-32'sd3, 32'sd1, 1, 8'sd0, -8'sd1, 8'sd0};
    vecs[3]  = '{32'sd5, 32'sd1, 1, 8'sd0, 8'sd3, 8'sd3};
    vecs[4]  = '{32'sd1000000, 32'sd1, 0, 8'sd5, 8'sd127, 8'sd127};
    vecs[5]  = '{-32'sd1000000, 32'sd1, 0, 8'sd5, -8'sd128, 8'sd5};
    vecs[6]  = '{-32'sd2, 32'sd1, 1, 8'sd0, -8'sd1, 8'sd0};
    vecs[7]  = '{32'sd7, 32'sd3, 2, -8'sd4, 8'sd1, 8'sd1};
    vecs[8]  = '{32'sh8000_0000, 32'sh8000_0000, 63, 8'sd0, 8'sd1, 8'sd1};
    vecs[9]  = '{32'sh7fff_ffff, 32'sh7fff_ffff, 0, 8'sd0, 8'sd127, 8'sd127};
    vecs[10] = '{32'sd100, -32'sd3, 2, 8'sd10, -8'sd65, 8'sd10};
    vecs[11] = '{-32'sd5, 32'sd1, 1, -8'sd128, -8'sd128, -8'sd128};

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        128'({m_bus.valid, m_bus.data, s_bus.ready, next_group, layer_done}), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 128'({m_bus.valid, s_bus.ready, layer_done}), 128'(0));

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Degenerate layers: zero pixels, then fewer channels than one group.
    start_layer(10'd8, 12'd0);
    chk("zero_pix_done", 128'({layer_done, s_bus.ready}), 128'(2'b10));
    @(negedge clk);
    chk("zero_pix_idle", 128'({layer_done, s_bus.ready}), 128'(0));
    start_layer(10'd4, 12'd2);
    chk("small_ch_done", 128'({layer_done, s_bus.ready}), 128'(2'b10));
    @(negedge clk);
    chk("small_ch_idle", 128'({layer_done, s_bus.ready}), 128'(0));

    for (int r = 0; r < 2; r++) begin
      rand_setup(8);
      exp_q.delete();
      n_in  = 0;
      n_out = 0;
      start_layer(10'd16, 12'd4);
      stream($sformatf("rand%0d", r), 8, 4, 65, 60);
    end

    // Fill the pipe with the sink stalled, hold it, then release.
    rand_setup(4);
    exp_q.delete();
    n_in  = 0;
    n_out = 0;
    start_layer(10'd8, 12'd4);
    m_bus.ready = 1'b0;
    cyc = 0;
    scale = sc_g[0];
    shift = 6'(sh_g[0]);
    zp    = zp_g[0];
    s_bus.valid = 1'b1;
    s_bus.data  = items[0];
    #1;
    while (!(m_bus.valid && !s_bus.ready) && cyc < 20) begin
      if (s_bus.ready) begin
        exp_q.push_back(ref_vec(items[n_in], sc_g[0], sh_g[0], zp_g[0]));
        n_in++;
      end
      @(negedge clk);
      cyc++;
      s_bus.data = items[n_in];
      #1;
    end
    chk("stall_fill_count", 128'(n_in), 128'(3));
    held = m_bus.data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall_hold%0d", i),
          128'({s_bus.ready, m_bus.valid, m_bus.data}), 128'({2'b01, held}));
    end
    s_bus.valid = 1'b0;
    stream("stall_release", 4, 4, 100, 100);

    // Reset with two transfers in flight, then a clean layer.
    rand_setup(2);
    start_layer(10'd8, 12'd4);
    m_bus.ready = 1'b1;
    s_bus.valid = 1'b1;
    s_bus.data  = items[0];
    #1;
    chk("rst_test_ready", 128'(s_bus.ready), 128'(1));
    @(negedge clk);
    s_bus.data = items[1];
    @(negedge clk);
    s_bus.valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_clear", 128'({m_bus.valid, s_bus.ready, layer_done}), 128'(0));
    rst  = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_bus.valid) seen++;
    end
    chk("rst_mid_no_output", 128'(seen), 128'(0));
    run_vec(vecs[1], "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
